// File: rtl/aqed_fifo_if.sv
// Handshake bundle observed by the A-QED FIFO monitor.
// The harness (or the bench) drives it, and the monitor listens.
interface aqed_fifo_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              orig_sel;
    logic              dup_sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, orig_sel, dup_sel,
        output out_valid, out_ready, out_data
    );

    modport slave (
        input in_valid, in_data, orig_sel, dup_sel,
        input out_valid, out_ready, out_data
    );
endinterface

// File: rtl/aqed_fifo_monitor.sv
// A-QED functional-consistency and occupancy monitor for FIFO-mode cores.
// It tags an original and a duplicate input, then compares the outputs at their ordinal positions.
module aqed_fifo_monitor #(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16,
    parameter int BOUND   = 64,
    parameter int BOUND_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             flush,
    input  logic [CNT_W-1:0] depth,
    aqed_fifo_if.slave       bus,
    output logic             qed_done,
    output logic             qed_check,
    output logic             bound_fail,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic [CNT_W-1:0] occupancy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ORIG = 2'd1;
    localparam logic [1:0] S_DUP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [BOUND_W-1:0] BMAX = BOUND_W'(BOUND);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   in_count;
    logic [CNT_W-1:0]   out_count;
    logic [CNT_W-1:0]   orig_idx;
    logic [CNT_W-1:0]   dup_idx;
    logic [DATA_W-1:0]  orig_data;
    logic [DATA_W-1:0]  orig_out;
    logic [DATA_W-1:0]  dup_out;
    logic               orig_got;
    logic               dup_got;
    logic [BOUND_W-1:0] bcnt;

    logic              in_acc;
    logic              out_acc;
    logic              orig_tag;
    logic              dup_tag;
    logic              orig_on;
    logic              dup_on;
    logic [CNT_W-1:0]  orig_pos;
    logic [CNT_W-1:0]  dup_pos;
    logic              orig_cap;
    logic              dup_cap;
    logic              finish;
    logic [DATA_W-1:0] orig_val;
    logic [DATA_W-1:0] dup_val;

    assign in_acc  = clk_en & bus.in_valid;
    assign out_acc = clk_en & bus.out_valid & bus.out_ready;

    assign orig_tag = (state == S_IDLE) & in_acc & bus.orig_sel;
    assign dup_tag  = (state == S_ORIG) & in_acc & bus.dup_sel
                    & ~bus.orig_sel & (bus.in_data == orig_data);

    // A same-cycle tag must be visible to capture for fall-through cores.
    assign orig_on  = (state != S_IDLE) | orig_tag;
    assign dup_on   = (state == S_DUP) | (state == S_DONE) | dup_tag;
    assign orig_pos = orig_tag ? in_count : orig_idx;
    assign dup_pos  = dup_tag ? in_count : dup_idx;

    assign orig_cap = out_acc & orig_on & ~orig_got
                    & (out_count == orig_pos);
    assign dup_cap  = out_acc & dup_on & ~dup_got
                    & (out_count == dup_pos);

    assign orig_val = orig_cap ? bus.out_data : orig_out;
    assign dup_val  = dup_cap ? bus.out_data : dup_out;

    assign finish = ((state == S_DUP) | dup_tag)
                  & (orig_got | orig_cap) & (dup_got | dup_cap);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (orig_tag) state_nxt = S_ORIG;
            S_ORIG: if (dup_tag) state_nxt = finish ? S_DONE : S_DUP;
            S_DUP:  if (finish) state_nxt = S_DONE;
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            in_count      <= '0;
            out_count     <= '0;
            occupancy     <= '0;
            orig_idx      <= '0;
            dup_idx       <= '0;
            orig_data     <= '0;
            orig_out      <= '0;
            dup_out       <= '0;
            orig_got      <= 1'b0;
            dup_got       <= 1'b0;
            bcnt          <= '0;
            qed_done      <= 1'b0;
            qed_check     <= 1'b0;
            bound_fail    <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                state         <= S_IDLE;
                in_count      <= '0;
                out_count     <= '0;
                occupancy     <= '0;
                orig_idx      <= '0;
                dup_idx       <= '0;
                orig_data     <= '0;
                orig_out      <= '0;
                dup_out       <= '0;
                orig_got      <= 1'b0;
                dup_got       <= 1'b0;
                bcnt          <= '0;
                qed_done      <= 1'b0;
                qed_check     <= 1'b0;
                bound_fail    <= 1'b0;
                overflow_err  <= 1'b0;
                underflow_err <= 1'b0;
            end else begin
                state     <= state_nxt;
                in_count  <= in_count + CNT_W'(in_acc);
                out_count <= out_count + CNT_W'(out_acc);
                occupancy <= occupancy + CNT_W'(in_acc)
                           - CNT_W'(out_acc);
                if (orig_tag) begin
                    orig_idx  <= in_count;
                    orig_data <= bus.in_data;
                end
                if (dup_tag) dup_idx <= in_count;
                if (orig_cap) begin
                    orig_got <= 1'b1;
                    orig_out <= bus.out_data;
                end
                if (dup_cap) begin
                    dup_got <= 1'b1;
                    dup_out <= bus.out_data;
                end
                if (finish) begin
                    qed_done  <= 1'b1;
                    qed_check <= (orig_val == dup_val);
                end
                // Fail flags on the same edge the counter reaches the bound.
                if (dup_tag && !finish) begin
                    bcnt <= '0;
                end else if (state == S_DUP && !finish) begin
                    if (bcnt != BMAX) bcnt <= bcnt + 1'b1;
                    if (bcnt >= BMAX - 1'b1) bound_fail <= 1'b1;
                end
                if (in_acc && !out_acc && occupancy >= depth)
                    overflow_err <= 1'b1;
                if (out_acc && !in_acc && occupancy == '0)
                    underflow_err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/aqed_fifo_monitor.md
# aqed_fifo_monitor

Parametrised A-QED functional-consistency and occupancy monitor for streaming FIFO-mode memory cores. It observes the DUT's input and output handshakes and tags one accepted input as the *original* and a later identical-data input as the *duplicate*. It captures the matching outputs by ordinal position and reports whether they agree. It also checks occupancy against the configured depth and enforces a response bound. It sits beside the memory core in the formal harness, replacing ad-hoc count/assume logic.

## Interface
- DATA_W, 16, data width of DUT input/output
- CNT_W, 16, width of ordinal and occupancy counters
- BOUND, 64, max cycles from duplicate capture to `qed_done` before `bound_fail`
- BOUND_W, 8, width of bound counter; BOUND < 2^BOUND_W
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  global enable; all state holds when low
- flush  in  1  synchronous clear of all state except config (same effect as reset, sampled when clk_en=1)
- depth  in  CNT_W  configured FIFO depth; must be stable while running
- in_valid  in  1  DUT write strobe (wen)
- in_data  in  DATA_W  DUT write data
- orig_sel  in  1  free input: tag current accepted input as original
- dup_sel  in  1  free input: tag current accepted input as duplicate
- out_valid  in  1  DUT valid_out
- out_ready  in  1  consumer accept (ren, aligned to valid)
- out_data  in  DATA_W  DUT data_out
- qed_done  out  1  both tagged outputs captured (sticky)
- qed_check  out  1  captured outputs equal; meaningful only when qed_done=1
- bound_fail  out  1  sticky response-bound violation
- overflow_err  out  1  sticky: input accepted with occupancy ≥ depth
- underflow_err  out  1  sticky: output accepted with occupancy 0 and no same-cycle input
- occupancy  out  CNT_W  in_count − out_count, mod 2^CNT_W

## Operation
- in_acc = clk_en & in_valid; out_acc = clk_en & out_valid & out_ready.
- in_count/out_count: CNT_W ordinal counters, +1 per accept, wrap mod 2^CNT_W. Index comparisons are by equality.
- FSM states: IDLE, ORIG, DUP, DONE.
  - IDLE→ORIG on in_acc & orig_sel: store orig_idx=in_count, orig_data=in_data.
  - ORIG→DUP on in_acc & dup_sel & (in_data==orig_data): store dup_idx=in_count.
  - dup_sel is ignored on data mismatch, in IDLE, or when in the same cycle as orig_sel.
  - orig_sel is ignored outside IDLE.
  - Output capture is independent of state. On out_acc with out_count==orig_idx and orig tagged (including a same-cycle tag), latch orig_out and set orig_got. Dup is handled the same way into dup_out/dup_got.
  - DUP→DONE when orig_got & dup_got, counting a capture occurring this cycle. DONE is terminal until reset/flush.
- qed_done=1 in DONE. qed_check=(orig_out==dup_out), registered on entry to DONE.
- Bound counter: cleared on entry to DUP, +1 per clk_en cycle in DUP, saturates at BOUND. bound_fail sets when it reaches BOUND while in DUP.
- overflow_err sets on in_acc & ~out_acc & occupancy≥depth. A simultaneous in/out accept at full is legal.
- underflow_err sets on out_acc & ~in_acc & occupancy==0.

## Timing
- All outputs are registered. Reset/flush values: all flags 0, occupancy 0, FSM IDLE.
- qed_done and qed_check rise one cycle after the clock edge at which the last required output handshake is sampled.
- Zero-latency (fall-through) DUT is supported: a tag and its output capture may occur in the same cycle.
- Error flags rise one cycle after the offending handshake and stay set until reset/flush.
- Reset mid-operation: asynchronous, clears immediately; no partial capture survives.
- clk_en=0 freezes every register, including the bound counter.

## Test plan
- In-order FIFO, depth=4: write 0x00AA (orig_sel), 0x0011, 0x00AA (dup_sel), then read 3 -> qed_done=1, qed_check=1 one cycle after the 3rd read.
- Faulty DUT returns 0x00AB at position 2 -> qed_done=1, qed_check=0.
- dup_sel on 0x0055 after orig 0x00AA -> stays in ORIG; a later 0x00AA dup_sel is accepted.
- depth=2: write 3 with no reads -> overflow_err=1 after the 3rd write. Simultaneous read+write at occupancy 2 -> no error.
- BOUND=8, reads stalled after dup tag -> bound_fail=1 after 8 enabled cycles; with clk_en low for 5 of those, it rises 5 cycles later.
- Assert reset during DUP with orig_got=1 -> all outputs 0 immediately; the next tag sequence works normally.
